// File: rtl/vga_dither_out.sv
// Ordered-dither colour reducer for the VGA output path: IN_BITS -> OUT_BITS per channel
// through a Bayer matrix in a 2-stage pix_en pipeline. Define TEMPORAL_DITHER_EN to rotate the matrix per frame.
module vga_dither_out #(
  parameter int   CHANNELS    = 3,
  parameter int   IN_BITS     = 2,
  parameter int   OUT_BITS    = 1,
  parameter int   MATRIX_LOG2 = 1,
  parameter logic SYNC_IDLE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pix_en,
  input  logic [CHANNELS*IN_BITS-1:0]  in_rgb,
  input  logic                         in_hsync,
  input  logic                         in_vsync,
  input  logic                         in_de,
  output logic [CHANNELS*OUT_BITS-1:0] out_rgb,
  output logic                         out_hsync,
  output logic                         out_vsync,
  output logic                         out_de,
  output logic [1:0]                   frame_phase
);

  localparam int D_BITS = IN_BITS - OUT_BITS;
  localparam int D_W    = (D_BITS > 0) ? D_BITS : 1;
  localparam int T_BITS = 2 * MATRIX_LOG2;
  localparam int SH_R   = (T_BITS >= D_BITS) ? T_BITS - D_BITS : 0;
  localparam int SH_L   = (T_BITS >= D_BITS) ? 0 : D_BITS - T_BITS;

  // Bayer entry built by bit interleaving: each level contributes {x^y, y}, finest level on top.
  // The result is already aligned to the D_BITS-wide remainder it is compared against.
  function automatic logic [D_W-1:0] scaled_threshold(input logic [MATRIX_LOG2-1:0] x,
                                                      input logic [MATRIX_LOG2-1:0] y);
    int t;
    t = 0;
    for (int i = 0; i < MATRIX_LOG2; i++) begin
      t = (t << 2) | (int'(x[i] ^ y[i]) << 1) | int'(y[i]);
    end
    t = (t >> SH_R) << SH_L;
    return D_W'(t);
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // NOTE: every clocked register uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Screen position tracking from de/vsync edges
  logic [MATRIX_LOG2-1:0] r_x;
  logic [MATRIX_LOG2-1:0] r_y;
  logic                   r_de_prev;
  logic                   r_vs_prev;
  logic                   w_de_rise;
  logic                   w_de_fall;
  logic                   w_vs_lead;
  logic [MATRIX_LOG2-1:0] w_x_cur;
  logic [MATRIX_LOG2-1:0] w_y_cur;
  logic [MATRIX_LOG2-1:0] w_x_eff;
  logic [MATRIX_LOG2-1:0] w_y_eff;

  assign w_de_rise = in_de & ~r_de_prev;
  assign w_de_fall = ~in_de & r_de_prev;
  assign w_vs_lead = (in_vsync != SYNC_IDLE) && (r_vs_prev == SYNC_IDLE);
  assign w_x_cur   = w_de_rise ? '0 : r_x;
  assign w_y_cur   = w_vs_lead ? '0 : r_y;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_de_prev <= 1'b0;
      r_vs_prev <= SYNC_IDLE;
    end else if (pix_en) begin
      r_de_prev <= in_de;
      r_vs_prev <= in_vsync;
      if (in_de) r_x <= w_x_cur + MATRIX_LOG2'(1);
      // A vsync leading edge wins over a same-sample line end.
      if (w_vs_lead)      r_y <= '0;
      else if (w_de_fall) r_y <= r_y + MATRIX_LOG2'(1);
    end
  end

`ifdef TEMPORAL_DITHER_EN
  logic [1:0] r_frame;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)               r_frame <= 2'd0;
    else if (pix_en && w_vs_lead) r_frame <= r_frame + 2'd1;
  end

  assign w_x_eff     = w_x_cur ^ {MATRIX_LOG2{r_frame[0]}};
  assign w_y_eff     = w_y_cur ^ {MATRIX_LOG2{r_frame[1]}};
  assign frame_phase = r_frame;
`else
  assign w_x_eff     = w_x_cur;
  assign w_y_eff     = w_y_cur;
  assign frame_phase = 2'b00;
`endif

  // Stage 1: source pixel, syncs and its threshold
  logic [CHANNELS*IN_BITS-1:0] r_s1_rgb;
  logic [D_W-1:0]              r_s1_ts;
  logic                        r_s1_hsync;
  logic                        r_s1_vsync;
  logic                        r_s1_de;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_rgb   <= '0;
      r_s1_ts    <= '0;
      r_s1_hsync <= SYNC_IDLE;
      r_s1_vsync <= SYNC_IDLE;
      r_s1_de    <= 1'b0;
    end else if (pix_en) begin
      r_s1_rgb   <= in_rgb;
      r_s1_ts    <= scaled_threshold(w_x_eff, w_y_eff);
      r_s1_hsync <= in_hsync;
      r_s1_vsync <= in_vsync;
      r_s1_de    <= in_de;
    end
  end

  logic [CHANNELS*OUT_BITS-1:0] w_dith;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (D_BITS == 0) begin : g_pass
      assign w_dith[c*OUT_BITS +: OUT_BITS] = r_s1_rgb[c*IN_BITS +: IN_BITS];
    end else begin : g_dith
      logic [OUT_BITS-1:0] w_hi;
      logic [D_W-1:0]      w_lo;
      logic                w_bump;
      logic [OUT_BITS:0]   w_sum;

      assign w_hi   = r_s1_rgb[c*IN_BITS + D_BITS +: OUT_BITS];
      assign w_lo   = r_s1_rgb[c*IN_BITS +: D_W];
      assign w_bump = (w_lo > r_s1_ts);
      // One extra carry bit so an all-ones high part saturates instead of wrapping.
      assign w_sum  = {1'b0, w_hi} + {{OUT_BITS{1'b0}}, w_bump};
      assign w_dith[c*OUT_BITS +: OUT_BITS] =
        w_sum[OUT_BITS] ? {OUT_BITS{1'b1}} : w_sum[OUT_BITS-1:0];
    end
  end

  // Stage 2: dithered colour, blanked outside active video
  logic [CHANNELS*OUT_BITS-1:0] r_out_rgb;
  logic                         r_out_hsync;
  logic                         r_out_vsync;
  logic                         r_out_de;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_rgb   <= '0;
      r_out_hsync <= SYNC_IDLE;
      r_out_vsync <= SYNC_IDLE;
      r_out_de    <= 1'b0;
    end else if (pix_en) begin
      r_out_rgb   <= r_s1_de ? w_dith : '0;
      r_out_hsync <= r_s1_hsync;
      r_out_vsync <= r_s1_vsync;
      r_out_de    <= r_s1_de;
    end
  end

  assign out_rgb   = r_out_rgb;
  assign out_hsync = r_out_hsync;
  assign out_vsync = r_out_vsync;
  assign out_de    = r_out_de;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: default 2x2 instance plus a 4-bit->2-bit 4x4 instance, both checked
// every cycle against a frame-geometry model; honours TEMPORAL_DITHER_EN.
module tb_vga_dither_out;

  logic        clk;
  logic        reset_n;
  logic        pix_en;
  logic [5:0]  in_rgb;
  logic [11:0] in_rgb2;
  logic        in_hsync;
  logic        in_vsync;
  logic        in_de;
  logic [2:0]  out_rgb;
  logic [5:0]  out_rgb2;
  logic        out_hsync, out_vsync, out_de;
  logic        out_hsync2, out_vsync2, out_de2;
  logic [1:0]  frame_phase, frame_phase2;

  vga_dither_out u_dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .in_rgb(in_rgb),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .out_rgb(out_rgb), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_de(out_de), .frame_phase(frame_phase)
  );

  vga_dither_out #(.IN_BITS(4), .OUT_BITS(2), .MATRIX_LOG2(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .in_rgb(in_rgb2),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .out_rgb(out_rgb2), .out_hsync(out_hsync2), .out_vsync(out_vsync2),
    .out_de(out_de2), .frame_phase(frame_phase2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Geometry of the sample being driven, known from how the stimulus builds each frame.
  int g_x, g_y, g_frame;
  logic prev_drv_vs;

  int B2 [2][2] = '{'{0, 2}, '{3, 1}};
  int B4 [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  function automatic int thr(int x, int y, int ml);
    int n, xe, ye;
    n  = 1 << ml;
    xe = x % n;
    ye = y % n;
`ifdef TEMPORAL_DITHER_EN
    if ((g_frame & 1) != 0) xe = xe ^ (n - 1);
    if ((g_frame & 2) != 0) ye = ye ^ (n - 1);
`endif
    if (ml == 1) return B2[ye][xe];
    else         return B4[ye][xe];
  endfunction

  function automatic int dith(int v, int t, int inb, int outb, int ml);
    int d, ts, hi, lo, r;
    d = inb - outb;
    if (d == 0) return v;
    ts = (2 * ml >= d) ? (t >> (2 * ml - d)) : (t << (d - 2 * ml));
    hi = v >> d;
    lo = v & ((1 << d) - 1);
    r  = hi + ((lo > ts) ? 1 : 0);
    if (r > (1 << outb) - 1) r = (1 << outb) - 1;
    return r;
  endfunction

  typedef struct {
    logic [2:0] rgb;
    logic [5:0] rgb2;
    logic       hs;
    logic       vs;
    logic       de;
  } exp_t;

  localparam exp_t IDLE = '{3'b000, 6'h00, 1'b1, 1'b1, 1'b0};

  function automatic exp_t predict();
    exp_t e;
    e.hs   = in_hsync;
    e.vs   = in_vsync;
    e.de   = in_de;
    e.rgb  = '0;
    e.rgb2 = '0;
    if (in_de) begin
      for (int c = 0; c < 3; c++) begin
        e.rgb[c]        = 1'(dith(int'(in_rgb[c*2 +: 2]), thr(g_x, g_y, 1), 2, 1, 1));
        e.rgb2[c*2 +: 2] = 2'(dith(int'(in_rgb2[c*4 +: 4]), thr(g_x, g_y, 2), 4, 2, 2));
      end
    end
    return e;
  endfunction

  // Output seen now = sample accepted two pix_en samples ago.
  exp_t       q[$];
  logic [1:0] exp_phase;
  bit         run_cmp = 0;

  initial begin
    q.push_back(IDLE);
    q.push_back(IDLE);
    exp_phase = 2'd0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q = {};
      q.push_back(IDLE);
      q.push_back(IDLE);
      exp_phase = 2'd0;
    end else if (pix_en) begin
      q.push_back(predict());
      void'(q.pop_front());
`ifdef TEMPORAL_DITHER_EN
      exp_phase = 2'(g_frame & 3);
`else
      exp_phase = 2'd0;
`endif
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_rgb",    32'(out_rgb),      32'(q[0].rgb));
      check("cmp_rgb2",   32'(out_rgb2),     32'(q[0].rgb2));
      check("cmp_hsync",  32'(out_hsync),    32'(q[0].hs));
      check("cmp_vsync",  32'(out_vsync),    32'(q[0].vs));
      check("cmp_de",     32'(out_de),       32'(q[0].de));
      check("cmp_de2",    32'(out_de2),      32'(q[0].de));
      check("cmp_hsync2", 32'(out_hsync2),   32'(q[0].hs));
      check("cmp_vsync2", 32'(out_vsync2),   32'(q[0].vs));
      check("cmp_phase",  32'(frame_phase),  32'(exp_phase));
      check("cmp_phase2", 32'(frame_phase2), 32'(exp_phase));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [5:0] rgb, input logic [11:0] rgb2, input logic hs,
                      input logic vs, input logic de, input int x, input int y, input int gap);
    if (vs == 1'b0 && prev_drv_vs == 1'b1) g_frame++;
    prev_drv_vs = vs;
    in_rgb   = rgb;
    in_rgb2  = rgb2;
    in_hsync = hs;
    in_vsync = vs;
    in_de    = de;
    g_x      = x;
    g_y      = y;
    repeat (gap) begin
      pix_en = 1'b0;
      tick();
    end
    pix_en = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(6'h00, 12'h000, 1'b1, 1'b1, 1'b0, 0, 0, 0);
  endtask

  function automatic logic [11:0] rand_rgb2();
    return ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
  endfunction

  task automatic random_frame(input int max_gap);
    int nl, np;
    repeat ($urandom_range(1, 3))
      step(6'($urandom), rand_rgb2(), 1'b1, 1'b0, 1'b0, 0, 0, $urandom_range(0, max_gap));
    step(6'($urandom), rand_rgb2(), 1'b1, 1'b1, 1'b0, 0, 0, $urandom_range(0, max_gap));
    nl = $urandom_range(2, 5);
    for (int l = 0; l < nl; l++) begin
      repeat ($urandom_range(1, 2))
        step(6'($urandom), rand_rgb2(), 1'b0, 1'b1, 1'b0, 0, l, $urandom_range(0, max_gap));
      step(6'($urandom), rand_rgb2(), 1'b1, 1'b1, 1'b0, 0, l, $urandom_range(0, max_gap));
      np = $urandom_range(1, 6);
      for (int p = 0; p < np; p++)
        step(6'($urandom), rand_rgb2(), 1'b1, 1'b1, 1'b1, p, l, $urandom_range(0, max_gap));
    end
    step(6'($urandom), rand_rgb2(), 1'b0, 1'b1, 1'b0, 0, 0, $urandom_range(0, max_gap));
  endtask

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       de;
    int         x;
    int         y;
    logic [2:0] e_static;
    logic [2:0] e_temporal;
    logic [5:0] e2;
  } dir_t;

  dir_t       dir_tab [15];
  logic [2:0] h_rgb[$];
  logic [5:0] h_rgb2[$];
  logic       h_hs[$], h_vs[$], h_de[$];

  initial begin
    dir_tab = '{
      '{6'h00, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h00, 1'b1, 1'b0, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h00, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h15, 1'b1, 1'b1, 1'b1, 0, 0, 3'b111, 3'b000, 6'h3F},
      '{6'h15, 1'b1, 1'b1, 1'b1, 1, 0, 3'b000, 3'b111, 6'h3F},
      '{6'h3F, 1'b0, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h00, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h15, 1'b1, 1'b1, 1'b1, 0, 1, 3'b000, 3'b111, 6'h3F},
      '{6'h15, 1'b1, 1'b1, 1'b1, 1, 1, 3'b111, 3'b000, 6'h3F},
      '{6'h3F, 1'b0, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h2A, 1'b1, 1'b1, 1'b1, 0, 2, 3'b111, 3'b111, 6'h3F},
      '{6'h2A, 1'b1, 1'b1, 1'b1, 1, 2, 3'b111, 3'b111, 6'h3F},
      '{6'h3F, 1'b1, 1'b1, 1'b1, 2, 2, 3'b111, 3'b111, 6'h3F},
      '{6'h3F, 1'b0, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00},
      '{6'h00, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000, 3'b000, 6'h00}
    };

    reset_n = 1'b0; pix_en = 1'b0; in_rgb = '0; in_rgb2 = '0;
    in_hsync = 1'b1; in_vsync = 1'b1; in_de = 1'b0;
    g_x = 0; g_y = 0; g_frame = 0; prev_drv_vs = 1'b1;
    tick();
    run_cmp = 1;
    tick();
    #2 reset_n = 1'b1;
    idle(4);

    // Directed: pix_en every cycle, literal expectations one sample behind the input.
    for (int i = 0; i < 15; i++) begin
      step(dir_tab[i].rgb, 12'hFFF, dir_tab[i].hs, dir_tab[i].vs, dir_tab[i].de,
           dir_tab[i].x, dir_tab[i].y, 0);
      h_rgb.push_back(out_rgb);
      h_rgb2.push_back(out_rgb2);
      h_hs.push_back(out_hsync);
      h_vs.push_back(out_vsync);
      h_de.push_back(out_de);
    end
    for (int i = 0; i < 14; i++) begin
`ifdef TEMPORAL_DITHER_EN
      check("lit_rgb", 32'(h_rgb[i+1]), 32'(dir_tab[i].e_temporal));
`else
      check("lit_rgb", 32'(h_rgb[i+1]), 32'(dir_tab[i].e_static));
`endif
      check("lit_rgb2_sat", 32'(h_rgb2[i+1]), 32'(dir_tab[i].e2));
      check("lit_hsync",    32'(h_hs[i+1]),   32'(dir_tab[i].hs));
      check("lit_vsync",    32'(h_vs[i+1]),   32'(dir_tab[i].vs));
      check("lit_de",       32'(h_de[i+1]),   32'(dir_tab[i].de));
    end

    // Random frames, first continuous then with pix_en gaps.
    repeat (2) random_frame(0);
    repeat (5) random_frame(2);

    // Reset in the middle of an active line.
    step(6'h00, 12'h000, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(6'h00, 12'h000, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    for (int p = 0; p < 4; p++)
      step(6'h3F, 12'hFFF, 1'b1, 1'b1, 1'b1, p, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_rgb",   32'(out_rgb),     32'h0);
    check("rst_rgb2",  32'(out_rgb2),    32'h0);
    check("rst_de",    32'(out_de),      32'h0);
    check("rst_hsync", 32'(out_hsync),   32'h1);
    check("rst_vsync", 32'(out_vsync),   32'h1);
    check("rst_phase", 32'(frame_phase), 32'h0);
    in_de = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1; in_rgb = '0; in_rgb2 = '0;
    g_frame = 0; prev_drv_vs = 1'b1;
    tick();
    tick();
    #2 reset_n = 1'b1;
    idle(4);

    repeat (5) random_frame(2);
    idle(3);

    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
